// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite write-channel controller.
// Holds the FSM encoding and the B-channel response codes.
package axil_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        MEM,
        RESP
    } wr_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_hold_slot.sv
// Single-entry valid/ready capture register with a full flag.
// Stays full until the controller releases it with clear.
module axil_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    output logic             ready,
    input  logic [WIDTH-1:0] data,
    input  logic             clear,
    output logic             full,
    output logic [WIDTH-1:0] q
);

    assign ready = rst_n && !full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
            q    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (valid && !full) begin
            full <= 1'b1;
            q    <= data;
        end
    end

endmodule

// File: rtl/axil_wr_ctrl.sv
// AXI-Lite slave write controller: joins AW and W beats,
// issues one register-bank write, then returns the B response.
module axil_wr_ctrl
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [ADDR_WIDTH-1:0]         AWADDR,
    input  logic                          WVALID,
    output logic                          WREADY,
    input  logic [DATA_WIDTH-1:0]         WDATA,
    input  logic [DATA_WIDTH/8-1:0]       WSTRB,
    output logic                          BVALID,
    input  logic                          BREADY,
    output logic [1:0]                    BRESP,
    output logic                          mem_we,
    output logic [$clog2(NUM_REGS)-1:0]   mem_idx,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [DATA_WIDTH/8-1:0]       mem_wstrb,
    input  logic                          mem_busy,
    output logic [7:0]                    err_count
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int W_W    = DATA_WIDTH + STRB_W;

    wr_state_t state, state_nx;

    logic                  aw_full;
    logic                  w_full;
    logic                  slot_clr;
    logic [ADDR_WIDTH-1:0] aw_q;
    logic [W_W-1:0]        w_q;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  decode_ok;
    logic [1:0]            bresp_q;
    logic [7:0]            err_q;

    axil_hold_slot #(.WIDTH(ADDR_WIDTH)) u_aw_slot (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .valid (AWVALID),
        .ready (AWREADY),
        .data  (AWADDR),
        .clear (slot_clr),
        .full  (aw_full),
        .q     (aw_q)
    );

    axil_hold_slot #(.WIDTH(W_W)) u_w_slot (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .valid (WVALID),
        .ready (WREADY),
        .data  ({WSTRB, WDATA}),
        .clear (slot_clr),
        .full  (w_full),
        .q     (w_q)
    );

    assign word_addr = aw_q >> 2;
    assign decode_ok = (aw_q[1:0] == 2'b00)
                    && (word_addr < ADDR_WIDTH'(NUM_REGS));

    assign mem_idx   = word_addr[IDX_W-1:0];
    assign mem_wdata = w_q[DATA_WIDTH-1:0];
    assign mem_wstrb = w_q[DATA_WIDTH +: STRB_W];

    always_ff @(posedge ACLK) begin
        if (!ARESETn) state <= COLLECT;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        slot_clr = 1'b0;
        unique case (state)
            COLLECT: begin
                if (aw_full && w_full) state_nx = MEM;
            end
            MEM: begin
                mem_we = ARESETn && decode_ok && !mem_busy;
                // a decode error retires without waiting on the bank
                if (!mem_busy || !decode_ok) begin
                    slot_clr = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (BREADY) state_nx = COLLECT;
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            bresp_q <= RESP_OKAY;
            err_q   <= 8'h00;
        end else if (slot_clr) begin
            bresp_q <= decode_ok ? RESP_OKAY : RESP_SLVERR;
            if (!decode_ok && err_q != 8'hFF) err_q <= err_q + 8'h01;
        end
    end

    assign BVALID    = (state == RESP);
    assign BRESP     = bresp_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_axil_wr_ctrl.sv
// Directed plus randomized bench for axil_wr_ctrl against a
// transaction-level reference model.
module tb_axil_wr_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        AWVALID;
    logic        AWREADY;
    logic [7:0]  AWADDR;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        mem_we;
    logic [3:0]  mem_idx;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_busy;
    logic [7:0]  err_count;

    axil_wr_ctrl #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .NUM_REGS   (16)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .AWADDR    (AWADDR),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .BRESP     (BRESP),
        .mem_we    (mem_we),
        .mem_idx   (mem_idx),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_busy  (mem_busy),
        .err_count (err_count)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int we_cnt   = 0;

    // reference model: what the slave holds, in transaction terms
    bit          m_aw_has, m_w_has;
    logic [7:0]  m_aw;
    logic [31:0] m_wd;
    logic [3:0]  m_ws;
    bit          m_writing;
    bit          m_resp_out;
    logic [1:0]  m_resp;
    int          m_errs;

    function automatic bit addr_ok(input logic [7:0] a);
        return (a % 4 == 0) && (a / 4 < 16);
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_aw_has   = 0;
        m_w_has    = 0;
        m_writing  = 0;
        m_resp_out = 0;
        m_resp     = 2'b00;
        m_errs     = 0;
    endtask

    task automatic check_outputs();
        bit ok, exp_we;
        int ec;
        ok     = addr_ok(m_aw);
        exp_we = ARESETn && m_writing && ok && !mem_busy;
        ec     = (m_errs > 255) ? 255 : m_errs;
        chk("awready", 64'(AWREADY), 64'(ARESETn && !m_aw_has));
        chk("wready", 64'(WREADY), 64'(ARESETn && !m_w_has));
        chk("bvalid", 64'(BVALID), 64'(m_resp_out));
        chk("mem_we", 64'(mem_we), 64'(exp_we));
        chk("err_count", 64'(err_count), 64'(ec));
        if (m_resp_out) chk("bresp", 64'(BRESP), 64'(m_resp));
        if (exp_we) begin
            chk("mem_idx", 64'(mem_idx), 64'(m_aw / 4));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_wd));
            chk("mem_wstrb", 64'(mem_wstrb), 64'(m_ws));
        end
        if (mem_we === 1'b1) we_cnt++;
    endtask

    task automatic model_edge();
        bit ok, start;
        if (!ARESETn) begin
            model_reset();
            return;
        end
        ok    = addr_ok(m_aw);
        start = !m_writing && !m_resp_out && m_aw_has && m_w_has;
        if (m_resp_out && BREADY) m_resp_out = 0;
        if (m_writing && (!ok || !mem_busy)) begin
            m_writing  = 0;
            m_resp_out = 1;
            m_resp     = ok ? 2'b00 : 2'b10;
            if (!ok) m_errs++;
            m_aw_has   = 0;
            m_w_has    = 0;
        end else begin
            if (AWVALID && !m_aw_has) begin
                m_aw_has = 1;
                m_aw     = AWADDR;
            end
            if (WVALID && !m_w_has) begin
                m_w_has = 1;
                m_wd    = WDATA;
                m_ws    = WSTRB;
            end
        end
        if (start) m_writing = 1;
    endtask

    // one clock: check mid-cycle, advance model on the edge
    task automatic cycle();
        @(negedge ACLK);
        check_outputs();
        @(posedge ACLK);
        model_edge();
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic put_aw(input logic [7:0] a);
        AWVALID = 1'b1;
        AWADDR  = a;
    endtask

    task automatic put_w(input logic [31:0] d, input logic [3:0] s);
        WVALID = 1'b1;
        WDATA  = d;
        WSTRB  = s;
    endtask

    task automatic idle_in();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
    endtask

    initial begin
        ARESETn  = 1'b0;
        AWVALID  = 1'b0;
        AWADDR   = '0;
        WVALID   = 1'b0;
        WDATA    = '0;
        WSTRB    = '0;
        BREADY   = 1'b1;
        mem_busy = 1'b0;
        m_aw = '0; m_wd = '0; m_ws = '0;
        model_reset();
        @(posedge ACLK);
        #1;
        cycle();
        ARESETn = 1'b1;
        cycle();

        // same-cycle AW and W
        we_cnt = 0;
        put_aw(8'h08);
        put_w(32'hDEADBEEF, 4'hF);
        cycle();
        idle_in();
        cycles(4);
        chk("t1_we_count", 64'(we_cnt), 64'd1);

        // W leads AW by three cycles
        we_cnt = 0;
        put_w(32'h12345678, 4'h3);
        cycle();
        WVALID = 1'b0;
        cycles(2);
        put_aw(8'h04);
        put_w(32'hFFFF0000, 4'hC);
        cycle();
        idle_in();
        cycles(4);
        chk("t2_we_count", 64'(we_cnt), 64'd1);

        // out-of-range then misaligned
        we_cnt = 0;
        put_aw(8'h40);
        put_w(32'h1, 4'hF);
        cycle();
        idle_in();
        cycles(4);
        put_aw(8'h05);
        put_w(32'h2, 4'hF);
        cycle();
        idle_in();
        cycles(4);
        chk("t3_we_count", 64'(we_cnt), 64'd0);
        chk("t3_err_count", 64'(err_count), 64'd2);

        // bank stall in MEM, with zero strobes
        we_cnt   = 0;
        mem_busy = 1'b1;
        put_aw(8'h0C);
        put_w(32'hA5A5A5A5, 4'h0);
        cycle();
        idle_in();
        cycles(5);
        mem_busy = 1'b0;
        cycles(4);
        chk("t4_we_count", 64'(we_cnt), 64'd1);

        // B back-pressure with the next beats presented
        we_cnt = 0;
        BREADY = 1'b0;
        put_aw(8'h10);
        put_w(32'h11111111, 4'hF);
        cycle();
        idle_in();
        cycles(3);
        put_aw(8'h14);
        put_w(32'h22222222, 4'h5);
        cycle();
        idle_in();
        cycles(5);
        chk("t5_we_held", 64'(we_cnt), 64'd1);
        BREADY = 1'b1;
        cycles(6);
        chk("t5_we_count", 64'(we_cnt), 64'd2);

        // reset while stalled in MEM
        we_cnt   = 0;
        mem_busy = 1'b1;
        put_aw(8'h18);
        put_w(32'h33333333, 4'hF);
        cycle();
        idle_in();
        cycles(2);
        ARESETn = 1'b0;
        cycle();
        ARESETn  = 1'b1;
        mem_busy = 1'b0;
        cycles(3);
        chk("t6_we_count", 64'(we_cnt), 64'd0);
        chk("t6_err_count", 64'(err_count), 64'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            AWVALID  = ($urandom_range(0, 99) < 50);
            WVALID   = ($urandom_range(0, 99) < 50);
            BREADY   = ($urandom_range(0, 99) < 70);
            mem_busy = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 1) == 0)
                AWADDR = 8'($urandom_range(0, 15) * 4);
            else
                AWADDR = 8'($urandom_range(0, 255));
            WDATA = $urandom;
            WSTRB = 4'($urandom_range(0, 15));
            cycle();
        end
        idle_in();
        BREADY   = 1'b1;
        mem_busy = 1'b0;
        cycles(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
